wb_spi_slave_fifo: RTL
======================

Name: wb_spi_slave_fifo

Overview:
Parametrised Wishbone-attached SPI slave with configurable word width, separate RX and TX FIFOs, and run-time selectable SPI mode (CPOL/CPHA, bit order). The external SPI pins are sampled and synchronised into the clk_i domain. The bus master sees four registers: DATA, STATUS, CTRL and IRQ_EN. This block replaces the single-byte, unbuffered SPI slave used on the peripheral bus, which has no mode selection, no buffering and no error reporting.

Parameters:
DATA_W, 8, SPI word width in bits; legal range 4..32; bus data zero-extended to 32.
FIFO_DEPTH, 8, entries per FIFO; power of 2, at least 2.
CPOL_RST, 0, CTRL.cpol reset value.
CPHA_RST, 0, CTRL.cpha reset value.

Ports:
clk_i  in  1  system clock; the only clock in the block
rst_ni  in  1  reset, synchronous, active-low
wb_cyc  in  1  Wishbone cycle
wb_stb  in  1  Wishbone strobe
wb_we  in  1  write enable
wb_adr  in  4  byte address; only [3:2] decoded
wb_data_m  in  32  write data, master to slave
wb_data_s  out  32  read data, slave to master
wb_ack  out  1  transfer acknowledge
wb_err  out  1  error; tied 0
wb_stall  out  1  stall; tied 0
sck_i  in  1  SPI clock (asynchronous)
cs_i  in  1  chip select, active-low (asynchronous)
mosi_i  in  1  SPI data in
miso_o  out  1  SPI data out
irq_o  out  1  level interrupt

Behaviour:
- Reset (rst_ni=0 at clk_i edge): both FIFOs empty; sticky flags cleared; CTRL={enable=0, lsb_first=0, cpha=CPHA_RST, cpol=CPOL_RST}; IRQ_EN=0. Outputs: wb_ack=0, wb_data_s=0, miso_o=0, irq_o=0. Synchroniser flops also cleared (cs treated as inactive). Reset mid-transfer discards the partial word.
- Register map, selected by adr[3:2]:
  - 0 DATA. Write pushes wb_data_m[DATA_W-1:0] into the TX FIFO; if TX full, the write is dropped and tx_ovf is set. Read pops the RX FIFO; if RX empty, returns 0 and no pop occurs.
  - 1 STATUS. Bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_ovf, [5] tx_unf, [6] tx_ovf, [7] cs_active, [15:8] rx_count, [23:16] tx_count. Bits [6:4] are sticky and write-1-to-clear; all others are read-only.
  - 2 CTRL. Bits: [0] cpol, [1] cpha, [2] lsb_first, [3] enable. Read/write.
  - 3 IRQ_EN. Bits: [0] rx_not_empty, [1] tx_empty, [2] any error flag. Read/write.
- Wishbone: a request is accepted on cyc&stb with no stall. wb_ack is asserted exactly one cycle after acceptance, for one cycle; wb_data_s is valid in the ack cycle. Back-to-back requests are acked on consecutive cycles. The DATA read pop takes effect at the acceptance edge.
- irq_o = |(IRQ_EN & {|STATUS[6:4], tx_empty, ~rx_empty}), registered; 1 cycle behind status.
- SPI input path:
  - sck_i, cs_i and mosi_i each pass through a 2-flop synchroniser, followed by edge detection on the synchronised sck and cs.
  - Requirement: f(clk_i) >= 4 x f(sck).
  - Effective clock is sck_s ^ cpol. Its rising edge is the leading edge; its falling edge is the trailing edge.
  - When enable=0, SPI edges are ignored and miso_o=0.
- Word start: on the cs fall edge with enable=1, bit counter=0 and the shift register loads the TX FIFO head (pop). If TX is empty, the shift register loads 0 and tx_unf is set.
- Bit order: lsb_first=0 selects MSB-first; 1 selects LSB-first. miso_o always drives the bit selected by lsb_first.
- cpha=0: the first bit is valid on miso_o from the cs fall. mosi is sampled on the leading edge and miso shifts on the trailing edge.
- cpha=1: miso shifts or presents on the leading edge; mosi is sampled on the trailing edge.
- Word completion: after DATA_W samples, the received word is pushed to RX on the cycle following the last sample. If RX is full, the word is dropped and rx_ovf is set. The next TX word is loaded per the word-start rule and the bit counter wraps to 0, giving continuous streaming while cs stays low.
- cs rise mid-word: the partial RX word is discarded, the bit counter is cleared, and miso_o=0 while cs is inactive.
- Simultaneous bus pop and SPI push on RX, or bus push and SPI pop on TX: both are performed and the count is unchanged. Full and empty flags reflect the post-update state.
- CTRL writes while cs is active take effect at the next cs fall.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, with the wrap bit distinguishing full from empty. Counts saturate at FIFO_DEPTH.

Test Plan:
- Reset, then read STATUS -> 0x0000_0005 (rx_empty, tx_empty). CTRL read = 0. irq_o=0. miso_o=0.
- DATA_W=8, mode 0, enable: write DATA 0xA5, then the master clocks 8 bits with mosi=0x3C -> miso sequence 1,0,1,0,0,1,0,1. STATUS rx_count=1. DATA read = 0x3C, after which rx_empty=1.
- Mode 3 (cpol=1, cpha=1), lsb_first=1: TX words 0x81, 0x7E streamed under one cs-low window -> miso bits LSB-first, 16 bits contiguous. RX receives 2 words in order.
- Fill RX with FIFO_DEPTH words, then send one more -> rx_full=1, rx_ovf=1, and the oldest 8 words are read back intact. W1C write of 0x10 to STATUS clears rx_ovf.
- cs low with TX empty -> tx_unf=1 and miso=0. Deassert cs after 3 bits -> no RX push and bit counter reset. The next full word is received correctly.
- IRQ_EN=1 with a word received -> irq_o=1 within 6 clk of the final sample edge. Pop via DATA read -> irq_o=0 two cycles later. Same-cycle pop and push -> rx_count unchanged.

Source files
------------

// File: rtl/wb_spi_slave_fifo_if.sv
// Wishbone bus bundle for wb_spi_slave_fifo: pipelined handshake, one request per cyc&stb cycle.
interface wb_spi_slave_fifo_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] data_m;
  logic [31:0] data_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, adr, data_m, input data_s, ack, err, stall);
  modport slave  (input cyc, stb, we, adr, data_m, output data_s, ack, err, stall);
endinterface

// File: rtl/wb_spi_slave_fifo.sv
// SPI slave with RX/TX FIFOs and run-time mode select, controlled over Wishbone.
// SPI pins are synchronised into clk_i; sck must run at no more than a quarter of clk_i.
module wb_spi_slave_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          CPOL_RST   = 1'b0,
  parameter bit          CPHA_RST   = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_spi_slave_fifo_if.slave wb,
  input  logic               sck_i,
  input  logic               cs_i,
  input  logic               mosi_i,
  output logic               miso_o,
  output logic               irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_W + 1);

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_IRQEN  = 2'd3;

  logic [1:0]        sck_q, cs_q, mosi_q;
  logic              sck_d, cs_d;
  logic              sck_s, cs_s, mosi_s;
  logic              cs_fall, cs_rise, lead, trail, sample_edge, shift_edge;
  logic              ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_en;
  logic              act_cpol, act_cpha, act_lsb, xfer;
  logic [2:0]        irq_en;
  logic              rx_ovf, tx_unf, tx_ovf;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [CW-1:0]     bit_cnt;
  logic              done;
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wp, rx_rp, tx_wp, tx_rp, rx_cnt, tx_cnt;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              acc, wr, rd;
  logic [1:0]        sel;
  logic              rx_pop, rx_push, tx_push, tx_pop, word_done, word_start;
  logic              rx_ovf_set, tx_ovf_set, tx_unf_set, w1c;
  logic [31:0]       status, rdata;
  logic              unused_bits;

  assign sck_s  = sck_q[1];
  assign cs_s   = cs_q[1];
  assign mosi_s = mosi_q[1];

  // Edges of the effective clock (sck ^ cpol), using the mode latched at cs fall
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign lead        = (sck_s ^ sck_d) & (sck_s ^ act_cpol);
  assign trail       = (sck_s ^ sck_d) & ~(sck_s ^ act_cpol);
  assign sample_edge = xfer & ~done & (act_cpha ? trail : lead);
  assign shift_edge  = xfer & (bit_cnt != '0) & (act_cpha ? lead : trail);

  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_empty = (rx_cnt == '0);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == PW'(FIFO_DEPTH));
  assign tx_full  = (tx_cnt == PW'(FIFO_DEPTH));

  assign acc = wb.cyc & wb.stb;
  assign sel = wb.adr[3:2];
  assign wr  = acc & wb.we;
  assign rd  = acc & ~wb.we;
  assign w1c = wr & (sel == ADR_STATUS);

  // A pop and push in the same cycle are both honoured even when the FIFO is full
  assign word_done  = xfer & done & ~cs_rise;
  assign word_start = (cs_fall & ctrl_en) | word_done;
  assign rx_pop     = rd & (sel == ADR_DATA) & ~rx_empty;
  assign tx_pop     = word_start & ~tx_empty;
  assign rx_push    = word_done & (~rx_full | rx_pop);
  assign tx_push    = wr & (sel == ADR_DATA) & (~tx_full | tx_pop);
  assign rx_ovf_set = word_done & ~rx_push;
  assign tx_ovf_set = wr & (sel == ADR_DATA) & ~tx_push;
  assign tx_unf_set = word_start & tx_empty;

  assign status = {8'd0, 8'(tx_cnt), 8'(rx_cnt), ~cs_s, tx_ovf, tx_unf, rx_ovf,
                   tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    rdata = '0;
    case (sel)
      ADR_DATA:   rdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp[AW-1:0]]);
      ADR_STATUS: rdata = status;
      ADR_CTRL:   rdata = {28'd0, ctrl_en, ctrl_lsb, ctrl_cpha, ctrl_cpol};
      ADR_IRQEN:  rdata = {29'd0, irq_en};
      default:    rdata = '0;
    endcase
  end

  assign wb.err      = 1'b0;
  assign wb.stall    = 1'b0;
  assign unused_bits = ^{wb.adr[1:0], wb.data_m};

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wb.data_m[DATA_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_q     <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      ctrl_cpol <= CPOL_RST;
      ctrl_cpha <= CPHA_RST;
      ctrl_lsb  <= 1'b0;
      ctrl_en   <= 1'b0;
      act_cpol  <= CPOL_RST;
      act_cpha  <= CPHA_RST;
      act_lsb   <= 1'b0;
      xfer      <= 1'b0;
      irq_en    <= '0;
      rx_ovf    <= 1'b0;
      tx_unf    <= 1'b0;
      tx_ovf    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      wb.ack    <= 1'b0;
      wb.data_s <= '0;
      miso_o    <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      sck_q  <= {sck_q[0], sck_i};
      cs_q   <= {cs_q[0], cs_i};
      mosi_q <= {mosi_q[0], mosi_i};
      sck_d  <= sck_s;
      cs_d   <= cs_s;

      // Shift engine: cs rise aborts, word start reloads, otherwise sample/shift
      if (cs_rise) begin
        xfer    <= 1'b0;
        bit_cnt <= '0;
        done    <= 1'b0;
      end else if (word_start) begin
        if (cs_fall) begin
          xfer     <= 1'b1;
          act_cpol <= ctrl_cpol;
          act_cpha <= ctrl_cpha;
          act_lsb  <= ctrl_lsb;
        end
        tx_sh   <= tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];
        bit_cnt <= '0;
        done    <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_sh   <= act_lsb ? {mosi_s, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi_s};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(DATA_W - 1)) done <= 1'b1;
        end
        if (shift_edge) tx_sh <= act_lsb ? (tx_sh >> 1) : (tx_sh << 1);
      end

      rx_wp <= rx_wp + PW'(rx_push);
      rx_rp <= rx_rp + PW'(rx_pop);
      tx_wp <= tx_wp + PW'(tx_push);
      tx_rp <= tx_rp + PW'(tx_pop);

      if (wr && sel == ADR_CTRL) {ctrl_en, ctrl_lsb, ctrl_cpha, ctrl_cpol} <= wb.data_m[3:0];
      if (wr && sel == ADR_IRQEN) irq_en <= wb.data_m[2:0];

      // Sticky error flags: a new event wins over a same-cycle clear
      rx_ovf <= rx_ovf_set | (rx_ovf & ~(w1c & wb.data_m[4]));
      tx_unf <= tx_unf_set | (tx_unf & ~(w1c & wb.data_m[5]));
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(w1c & wb.data_m[6]));

      wb.ack    <= acc;
      wb.data_s <= rd ? rdata : 32'd0;
      miso_o    <= (xfer & ~cs_rise) ? (act_lsb ? tx_sh[0] : tx_sh[DATA_W-1]) : 1'b0;
      irq_o     <= |(irq_en & {rx_ovf | tx_unf | tx_ovf, tx_empty, ~rx_empty});
    end
  end

endmodule
